// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uart_tx byte transmitter among N_REQ one-byte hold slots.
// Latency: accept edge t -> tx_flag pulse in the clock after edge t+1 when idle; issues spaced FRAME_CYC+GAP_CYCLES+1.
// Backpressure: req_ready[i] is low while slot i holds a byte and rises the clock after that byte is issued.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int CLKFREQ    = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FRAME_BITS = 10,
  parameter int GAP_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_flag,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int IDW       = $clog2(N_REQ);
  localparam int BIT_CYC   = CLKFREQ / BAUD;
  localparam int FRAME_CYC = BIT_CYC * FRAME_BITS;
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_CYC - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [7:0]       slot_q [N_REQ];
  logic [7:0]       slot_d [N_REQ];
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_flag_q, tx_flag_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             pick_vld;
  logic [IDW-1:0]   pick_id;
  logic [7:0]       pick_dat;
  logic             hi_vld, lo_vld;
  logic [IDW-1:0]   hi_id, lo_id;
  logic [7:0]       hi_dat, lo_dat;

  // Cyclic scan after last: lowest pending index above last wins, else lowest at or below it.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    hi_dat = '0;
    lo_dat = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        if (IDW'(k) > last_q) begin
          hi_vld = 1'b1;
          hi_id  = IDW'(k);
          hi_dat = slot_q[k];
        end else begin
          lo_vld = 1'b1;
          lo_id  = IDW'(k);
          lo_dat = slot_q[k];
        end
      end
    end
    pick_vld = hi_vld | lo_vld;
    pick_id  = hi_vld ? hi_id  : lo_id;
    pick_dat = hi_vld ? hi_dat : lo_dat;
  end

  always_comb begin
    pend_d = pend_q;
    slot_d = slot_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (req_valid[k] && !pend_q[k]) begin
        pend_d[k] = 1'b1;
        slot_d[k] = req_data[8*k +: 8];
      end
    end
    // A slot cannot be refilled while pending, so this clear never races an accept.
    if (state_q == S_ISSUE) begin
      pend_d[grant_q] = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    tx_flag_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (pick_vld) begin
          grant_d   = pick_id;
          last_d    = pick_id;
          tx_data_d = pick_dat;
          tx_flag_d = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 16'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == FRAME_LAST) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      grant_q   <= '0;
      last_q    <= IDW'(N_REQ - 1);
      tx_data_q <= '0;
      tx_flag_q <= 1'b0;
      cnt_q     <= '0;
      for (int k = 0; k < N_REQ; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      tx_data_q <= tx_data_d;
      tx_flag_q <= tx_flag_d;
      cnt_q     <= cnt_d;
      for (int k = 0; k < N_REQ; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  assign req_ready = ~pend_q;
  assign tx_data   = tx_data_q;
  assign tx_flag   = tx_flag_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter: directed loads, round-robin order, spacing, reset, gap + serial decode.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N       = 4;
  localparam int BIT_CYC = 434;
  localparam int FRAME   = 4340;
  localparam int SPACE   = FRAME + 1;
  localparam int GSPACE  = FRAME + 100 + 1;
  localparam int BOUND   = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, g_rst_n;
  logic [N-1:0]   req_valid, req_ready, g_req_valid, g_req_ready;
  logic [8*N-1:0] req_data, g_req_data;
  logic [7:0]     tx_data, g_tx_data;
  logic           tx_flag, g_tx_flag, busy, g_busy;
  logic [1:0]     grant_id, g_grant_id;

  uart_tx_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_flag(tx_flag),
    .grant_id(grant_id), .busy(busy));

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(100)) dut_gap (
    .clk(clk), .rst_n(g_rst_n), .req_valid(g_req_valid), .req_data(g_req_data),
    .req_ready(g_req_ready), .tx_data(g_tx_data), .tx_flag(g_tx_flag),
    .grant_id(g_grant_id), .busy(g_busy));

  typedef struct { int id; logic [7:0] data; int gap; } exp_t;
  exp_t       exp_q[$];
  exp_t       g_exp_q[$];
  logic [7:0] g_rx_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int flag_cnt = 0;
  int last_flag = 0;
  int last_brun = 0;
  int acc_cyc = 0;
  int g_flag_cnt = 0;
  int g_rx_cnt = 0;
  bit g_done = 1'b0;
  logic g_line;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out after %0d cycles", name, BOUND);
  endtask

  task automatic expect_issue(input int id, input logic [7:0] d, input int gap);
    exp_t e;
    e.id = id; e.data = d; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic send(input int i, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!req_ready[i] && n < BOUND) begin @(negedge clk); n++; end
    if (n >= BOUND) timeout("send_ready");
    req_valid[i] = 1'b1;
    req_data[8*i +: 8] = b;
    @(negedge clk);
    acc_cyc = cyc;
    req_valid[i] = 1'b0;
  endtask

  task automatic g_send(input int i, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!g_req_ready[i] && n < BOUND) begin @(negedge clk); n++; end
    if (n >= BOUND) timeout("g_send_ready");
    g_req_valid[i] = 1'b1;
    g_req_data[8*i +: 8] = b;
    @(negedge clk);
    g_req_valid[i] = 1'b0;
  endtask

  task automatic wait_flag(input int base);
    int n = 0;
    while (flag_cnt <= base && n < BOUND) begin @(negedge clk); n++; end
    if (n >= BOUND) timeout("wait_flag");
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 40000) begin @(negedge clk); n++; end
    if (n >= 40000) timeout("wait_drain");
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, req_ready, 4'hF);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_flag"}, tx_flag, 0);
    check({tag, "_data"}, tx_data, 0);
    check({tag, "_grant"}, grant_id, 0);
  endtask

  // Monitor: pops the scoreboard on each tx_flag and tracks pulse width, data hold and busy run.
  initial begin : mon
    exp_t e;
    bit prev_flag = 0;
    bit hold_ok = 1;
    logic [7:0] hold = '0;
    int brun = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_flag = 0; hold = '0; hold_ok = 1; brun = 0;
      end else begin
        if (tx_flag) begin
          flag_cnt++;
          check("flag_width", prev_flag, 0);
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_flag: grant %0d data 0x%0h with nothing expected", grant_id, tx_data);
          end else begin
            e = exp_q.pop_front();
            check("grant_id", grant_id, e.id);
            check("tx_data", tx_data, e.data);
            if (e.gap != 0) check("flag_spacing", cyc - last_flag, e.gap);
            check("tx_data_hold", hold_ok, 1);
          end
          last_flag = cyc; hold = tx_data; hold_ok = 1;
        end else if (tx_data !== hold) begin
          hold_ok = 0;
        end
        if (busy) brun++;
        else if (brun != 0) begin last_brun = brun; brun = 0; end
        prev_flag = tx_flag;
      end
    end
  end

  // Gap instance: line serializer standing in for uart_tx, plus mid-bit receiver.
  initial begin : ser
    logic [9:0] fr;
    g_line = 1'b1;
    forever begin
      @(negedge clk);
      if (g_tx_flag && g_rst_n) begin
        fr = {1'b1, g_tx_data, 1'b0};
        for (int b = 0; b < 10; b++) begin
          g_line = fr[b];
          repeat (BIT_CYC) @(negedge clk);
        end
      end
    end
  end

  initial begin : rx
    logic [7:0] rb;
    forever begin
      @(negedge clk);
      if (g_line === 1'b0) begin
        repeat (BIT_CYC / 2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (BIT_CYC) @(negedge clk);
          rb[b] = g_line;
        end
        repeat (BIT_CYC) @(negedge clk);
        check("rx_stop", g_line, 1);
        if (g_rx_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rx_unexpected: got 0x%0h with nothing expected", rb);
        end else check("rx_byte", rb, g_rx_q.pop_front());
        g_rx_cnt++;
      end
    end
  end

  initial begin : g_mon
    exp_t e;
    int g_last = 0;
    forever begin
      @(negedge clk);
      if (g_rst_n && g_tx_flag) begin
        g_flag_cnt++;
        if (g_exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL g_unexpected_flag: grant %0d data 0x%0h", g_grant_id, g_tx_data);
        end else begin
          e = g_exp_q.pop_front();
          check("g_grant_id", g_grant_id, e.id);
          check("g_tx_data", g_tx_data, e.data);
          if (e.gap != 0) check("g_flag_spacing", cyc - g_last, e.gap);
        end
        g_last = cyc;
      end
    end
  end

  initial begin : g_flow
    exp_t e;
    int n = 0;
    g_rst_n = 1'b0; g_req_valid = '0; g_req_data = '0;
    repeat (3) @(negedge clk);
    g_rst_n = 1'b1;
    e.id = 2; e.data = 8'hC3; e.gap = 0;      g_exp_q.push_back(e);
    e.id = 0; e.data = 8'h5A; e.gap = GSPACE; g_exp_q.push_back(e);
    e.id = 1; e.data = 8'h96; e.gap = GSPACE; g_exp_q.push_back(e);
    g_rx_q.push_back(8'hC3); g_rx_q.push_back(8'h5A); g_rx_q.push_back(8'h96);
    g_send(2, 8'hC3);
    repeat (5) @(negedge clk);
    g_send(0, 8'h5A);
    repeat (5) @(negedge clk);
    g_send(1, 8'h96);
    while (g_rx_cnt < 3 && n < 30000) begin @(negedge clk); n++; end
    if (n >= 30000) timeout("g_rx_wait");
    check("g_rx_count", g_rx_cnt, 3);
    check("g_flag_count", g_flag_cnt, 3);
    g_done = 1'b1;
  end

  initial begin : main
    int base;
    int n;
    rst_n = 1'b0; req_valid = '0; req_data = '0;
    repeat (3) @(negedge clk);
    #1 check_reset_state("t1_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // T1: single byte, pulse at accept+1 sampled cycle, busy for ISSUE + (FRAME-1) WAIT clocks.
    expect_issue(0, 8'h0F, 0);
    base = flag_cnt;
    send(0, 8'h0F);
    check("t1_ready_low", req_ready[0], 0);
    @(negedge clk);
    check("t1_flag_cycle", tx_flag, 1);
    check("t1_ready_issue", req_ready[0], 0);
    @(negedge clk);
    check("t1_ready_back", req_ready[0], 1);
    check("t1_flag_off", tx_flag, 0);
    wait_flag(base);
    check("t1_latency", last_flag - acc_cyc, 1);
    wait_drain();
    check("t1_busy_len", last_brun, FRAME);

    // T2: four slots loaded in one clock after reset.
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1;
    #1 check_reset_state("t2_reset");
    expect_issue(0, 8'h10, 0);
    expect_issue(1, 8'h21, SPACE);
    expect_issue(2, 8'h32, SPACE);
    expect_issue(3, 8'h43, SPACE);
    @(negedge clk);
    req_valid = 4'hF;
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    @(negedge clk);
    req_valid = '0;
    wait_drain();

    // T3: last=1 with {0,3} pending wraps to 3 before 0.
    expect_issue(1, 8'h5B, 0);
    expect_issue(3, 8'h6C, SPACE);
    expect_issue(0, 8'h60, SPACE);
    base = flag_cnt;
    send(1, 8'h5B);
    wait_flag(base);
    send(0, 8'h60);
    send(3, 8'h6C);
    wait_drain();

    // T4: req2 streams five bytes while req1 has one.
    expect_issue(2, 8'hA0, 0);
    expect_issue(1, 8'hB7, SPACE);
    expect_issue(2, 8'hA1, SPACE);
    expect_issue(2, 8'hA2, SPACE);
    expect_issue(2, 8'hA3, SPACE);
    expect_issue(2, 8'hA4, SPACE);
    fork
      begin
        send(2, 8'hA0); send(2, 8'hA1); send(2, 8'hA2); send(2, 8'hA3); send(2, 8'hA4);
      end
      begin
        repeat (10) @(negedge clk);
        send(1, 8'hB7);
      end
    join
    wait_drain();

    // T5: reset mid-frame with slots 1,2 pending.
    expect_issue(0, 8'h77, 0);
    base = flag_cnt;
    send(0, 8'h77);
    send(1, 8'h88);
    send(2, 8'h99);
    wait_flag(base);
    repeat (1000) @(negedge clk);
    check("t5_pending", req_ready, 4'b1001);
    check("t5_busy_mid", busy, 1);
    rst_n = 1'b0;
    #1 check_reset_state("t5_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = flag_cnt;
    repeat (50) @(negedge clk);
    check("t5_no_issue", flag_cnt, base);
    check("t5_idle", busy, 0);
    expect_issue(3, 8'hE1, 0);
    send(3, 8'hE1);
    wait_flag(base);
    check("t5_latency", last_flag - acc_cyc, 1);
    wait_drain();

    n = 0;
    while (!g_done && n < 40000) begin @(negedge clk); n++; end
    if (n >= 40000) timeout("g_done");
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
